wb_cmd_master: RTL

- Single-outstanding Wishbone classic initiator that converts a valid/ready command stream into one bus cycle per command and returns a response.
- It drives the register-slave peripherals on the system bus, such as GPIO: OEN at 0x00, SET at 0x04, RESET at 0x08, READ at 0x10.
- A cycle with no acknowledge ends after a bounded timeout and reports an error.

---
 rtl/wb_cmd_master.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone classic initiator with ack timeout
module wb_cmd_master #(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_sys_i,
    input  logic          rst_n_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [DW-1:0] cmd_dat_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_dat_o,
    output logic          rsp_err_o,
    output logic [7:0]    err_cnt_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          cyc_q, cyc_nx;
    logic          we_nx;
    logic [AW-1:0] adr_nx;
    logic [DW-1:0] dat_nx;
    logic          rvalid_nx;
    logic [DW-1:0] rdat_nx;
    logic          rerr_nx;
    logic [7:0]    cnt_nx;

    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            timer       <= '0;
            cyc_q       <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            err_cnt_o   <= 8'd0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            cyc_q       <= cyc_nx;
            wb_we_o     <= we_nx;
            wb_adr_o    <= adr_nx;
            wb_dat_o    <= dat_nx;
            rsp_valid_o <= rvalid_nx;
            rsp_dat_o   <= rdat_nx;
            rsp_err_o   <= rerr_nx;
            err_cnt_o   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        cyc_nx    = cyc_q;
        we_nx     = wb_we_o;
        adr_nx    = wb_adr_o;
        dat_nx    = wb_dat_o;
        rvalid_nx = rsp_valid_o;
        rdat_nx   = rsp_dat_o;
        rerr_nx   = rsp_err_o;
        cnt_nx    = err_cnt_o;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_nx    = cmd_we_i;
                    adr_nx   = cmd_adr_i;
                    dat_nx   = cmd_dat_i;
                    cyc_nx   = 1'b1;
                    timer_nx = '0;
                    state_nx = BUS;
                end
            end
            BUS: begin
                // ack is checked first so an ack in the last allowed cycle still succeeds
                if (wb_ack_i) begin
                    cyc_nx    = 1'b0;
                    rdat_nx   = wb_we_o ? '0 : wb_dat_i;
                    rerr_nx   = 1'b0;
                    rvalid_nx = 1'b1;
                    state_nx  = RESP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    cyc_nx    = 1'b0;
                    rdat_nx   = '0;
                    rerr_nx   = 1'b1;
                    rvalid_nx = 1'b1;
                    if (err_cnt_o != 8'hFF) begin
                        cnt_nx = err_cnt_o + 8'd1;
                    end
                    state_nx  = RESP;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rvalid_nx = 1'b0;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cmd_ready_o = (state == IDLE);
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;

endmodule
